// File: rtl/ssd_pkg.sv
// ssd_pkg: shared definitions for the seven-segment display path.
// Holds the blank nibble code shared with the scanner, the default digit
// count, the converter state encoding and the decimal ceiling helper.
`timescale 1ns/1ps
package ssd_pkg;

  // Nibble value the scanner decodes as "all segments off".
  localparam logic [3:0] BLANK_CODE = 4'hF;

  // Digit count of the display; converter and scanner must agree on it.
  localparam int unsigned SSD_DIGITS = 4;

  // Largest value representable on SSD_DIGITS decimal digits.
  localparam int unsigned BCD_MAX = 9999;

  // Converter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } feed_state_t;

  // 10^digits - 1, used for the saturation threshold at any digit count.
  function automatic int unsigned bcd_max_for(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell.
// A BCD nibble of 5 or more gets 3 added so that the following left shift
// carries correctly into the next decimal digit.
//   i_nib : scratch nibble before correction
//   o_nib : corrected nibble
`timescale 1ns/1ps
module bcd_digit_adj (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    if (i_nib >= 4'd5) begin
      o_nib = i_nib + 4'd3;
    end else begin
      o_nib = i_nib;
    end
  end

endmodule

// File: rtl/bin_to_bcd_feed.sv
// bin_to_bcd_feed: sequential binary to packed-BCD converter feeding the
// seven-segment scanner. Runs shift-add-3 one bit per clock and holds the
// result stable between conversions.
//
// Ports:
//   CLK      : system clock, rising edge
//   RST_N    : asynchronous active-low reset
//   START    : conversion request, honoured only while idle
//   BIN_IN   : binary value, captured when START is honoured
//   BUSY     : conversion in progress
//   DONE     : one-cycle pulse, BCD_OUT just updated
//   OVERFLOW : last accepted value exceeded 10^DIGITS-1
//   BCD_OUT  : packed BCD, digit 0 in the least significant nibble
//
// Build option:
//   BIN_TO_BCD_FEED_BLANK_LEADING_EN : replace leading zero digits (never
//   digit 0) with BLANK_CODE in the published result. Saturated results
//   are all nines and so are never blanked.
`timescale 1ns/1ps
module bin_to_bcd_feed
  import ssd_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 14,
  parameter int unsigned DIGITS    = SSD_DIGITS
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [BIN_WIDTH-1:0]  BIN_IN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OVERFLOW,
  output logic [4*DIGITS-1:0]   BCD_OUT
);

  localparam int unsigned      SW       = 4 * DIGITS;
  localparam int unsigned      CW       = $clog2(BIN_WIDTH + 1);
  localparam int unsigned      MAX_VAL  = bcd_max_for(DIGITS);
  localparam logic [CW-1:0]    LAST_CNT = CW'(BIN_WIDTH - 1);

  feed_state_t            r_state;
  logic [BIN_WIDTH-1:0]   r_shift;
  logic [SW-1:0]          r_scratch;
  logic [CW-1:0]          r_count;
  logic                   r_ovf_pend;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_ovf;
  logic [SW-1:0]          r_bcd;

  logic [SW-1:0]          w_scratch_adj;
  logic [SW-1:0]          w_result;
  logic                   w_too_big;

  // Per-digit add-3 correction, all digits in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_nib (r_scratch[4*g +: 4]),
      .o_nib (w_scratch_adj[4*g +: 4])
    );
  end

  assign w_too_big = (32'(BIN_IN) > MAX_VAL);

`ifdef BIN_TO_BCD_FEED_BLANK_LEADING_EN
  logic w_leading;

  // Walk from the most significant digit down; blanking stops at the first
  // non-zero digit, and digit 0 is outside the walk so it always shows.
  always_comb begin
    w_result  = r_scratch;
    w_leading = 1'b1;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      if (w_leading && (r_scratch[4*(DIGITS-1-i) +: 4] == 4'h0)) begin
        w_result[4*(DIGITS-1-i) +: 4] = BLANK_CODE;
      end else begin
        w_leading = 1'b0;
      end
    end
    if (r_ovf_pend) begin
      w_result = {DIGITS{4'h9}};
    end
  end
`else
  always_comb begin
    w_result = r_scratch;
    if (r_ovf_pend) begin
      w_result = {DIGITS{4'h9}};
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_count    <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_shift    <= BIN_IN;
            r_scratch  <= '0;
            r_count    <= '0;
            r_ovf_pend <= w_too_big;
            r_busy     <= 1'b1;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // Corrected scratch and shift register move left as one word;
          // bits pushed past the top digit are dropped (saturation covers it).
          r_scratch <= {w_scratch_adj[SW-2:0], r_shift[BIN_WIDTH-1]};
          r_shift   <= {r_shift[BIN_WIDTH-2:0], 1'b0};
          r_count   <= r_count + CW'(1);
          if (r_count == LAST_CNT) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          r_bcd   <= w_result;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign OVERFLOW = r_ovf;
  assign BCD_OUT  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_feed.sv
`timescale 1ns/1ps
module tb_bin_to_bcd_feed;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [13:0] BIN_IN;
  logic        BUSY;
  logic        DONE;
  logic        OVERFLOW;
  logic [15:0] BCD_OUT;

  int          checks   = 0;
  int          errors   = 0;
  int          done_cnt = 0;
  logic [15:0] model_bcd = 16'h0000;
  logic        model_ovf = 1'b0;

  bin_to_bcd_feed #(
    .BIN_WIDTH (14),
    .DIGITS    (4)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .START    (START),
    .BIN_IN   (BIN_IN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .OVERFLOW (OVERFLOW),
    .BCD_OUT  (BCD_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (DONE === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; saturate above 9999.
  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned d[4];
    bit lead;
    if (v > 9999) return 16'h9999;
    d[0] = v % 10;
    d[1] = (v / 10) % 10;
    d[2] = (v / 100) % 10;
    d[3] = v / 1000;
    lead = 1'b1;
`ifdef BIN_TO_BCD_FEED_BLANK_LEADING_EN
    for (int k = 3; k >= 1; k--) begin
      if (lead && d[k] == 0) d[k] = 15;
      else lead = 1'b0;
    end
`endif
    return {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
  endfunction

  // Drives START now (caller sits between edges), waits for DONE and
  // checks latency, busy length, output hold and the result.
  task automatic run_conv(input int unsigned v);
    int lat;
    int busy_n;
    bit unstable;
    lat = 0;
    busy_n = 0;
    unstable = 1'b0;
    BIN_IN = 14'(v);
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    BIN_IN = 14'($urandom);
    if (BUSY === 1'b1) busy_n++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (DONE === 1'b1) begin
        lat = k;
        break;
      end
      if (BUSY === 1'b1) busy_n++;
      if (BCD_OUT !== model_bcd || OVERFLOW !== model_ovf) unstable = 1'b1;
    end
    check("latency", lat, 15);
    check("busy_cycles", busy_n, 15);
    check("hold_while_busy", {31'd0, unstable}, 0);
    check("busy_low_at_done", {31'd0, BUSY}, 0);
    model_bcd = ref_bcd(v);
    model_ovf = (v > 9999);
    check("bcd", {16'd0, BCD_OUT}, {16'd0, model_bcd});
    check("overflow", {31'd0, OVERFLOW}, {31'd0, model_ovf});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    int dc;
    int unsigned edges[11];
    edges = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
    START  = 1'b0;
    BIN_IN = '0;
    RST_N  = 1'b1;
    #3 RST_N = 1'b0;
    #1;
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_done", {31'd0, DONE}, 0);
    check("rst_ovf", {31'd0, OVERFLOW}, 0);
    check("rst_bcd", {16'd0, BCD_OUT}, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    idle(2);

    // Basic conversion with a single DONE pulse.
    dc = done_cnt;
    run_conv(1234);
    @(posedge CLK); #1;
    check("done_one_cycle", {31'd0, DONE}, 0);
    check("done_count_1234", done_cnt - dc, 1);
    idle(2);

    // Back-to-back: second START in the DONE cycle.
    dc = done_cnt;
    run_conv(0);
    run_conv(9999);
    idle(3);
    check("done_count_b2b", done_cnt - dc, 2);

    // Saturation then a small value.
    run_conv(12000);
    idle(1);
    run_conv(7);
    idle(2);

    // START while busy is ignored.
    dc = done_cnt;
    BIN_IN = 14'd500;
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    idle(4);
    BIN_IN = 14'd321;
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    for (int k = 0; k < 40 && DONE !== 1'b1; k++) begin
      @(posedge CLK); #1;
    end
    check("busy_ignore_bcd", {16'd0, BCD_OUT}, {16'd0, ref_bcd(500)});
    check("busy_ignore_ovf", {31'd0, OVERFLOW}, 0);
    model_bcd = ref_bcd(500);
    model_ovf = 1'b0;
    idle(20);
    check("busy_ignore_dones", done_cnt - dc, 1);
    check("busy_ignore_idle", {31'd0, BUSY}, 0);

    // Reset mid-conversion, with OVERFLOW and BCD_OUT non-zero beforehand.
    run_conv(12000);
    idle(1);
    dc = done_cnt;
    BIN_IN = 14'd8765;
    START  = 1'b1;
    @(posedge CLK); #1;
    START  = 1'b0;
    idle(6);
    RST_N = 1'b0;
    #1;
    check("midrst_busy", {31'd0, BUSY}, 0);
    check("midrst_done", {31'd0, DONE}, 0);
    check("midrst_ovf", {31'd0, OVERFLOW}, 0);
    check("midrst_bcd", {16'd0, BCD_OUT}, 0);
    model_bcd = 16'h0000;
    model_ovf = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    idle(25);
    check("midrst_no_done", done_cnt - dc, 0);
    check("midrst_idle", {31'd0, BUSY}, 0);
    run_conv(8765);
    idle(1);

    // Decade boundaries and the top of the input range.
    foreach (edges[i]) begin
      run_conv(edges[i]);
      idle(i % 2);
    end

    // Random values, mixing back-to-back and gapped requests.
    for (int n = 0; n < 300; n++) begin
      run_conv($urandom_range(16383, 0));
      if ((n % 4) != 0) idle($urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
